// File: rtl/dcache_pkg.sv
// Shared types and field widths for the direct-mapped data cache.
// Address split: [1:0] word offset, [INDEX_W+1:2] index, rest tag.
package dcache_pkg;

    localparam int NUM_LINES = 16;
    localparam int OFFSET_W  = 2;
    localparam int INDEX_W   = $clog2(NUM_LINES);
    localparam int TAG_W     = 32 - INDEX_W - OFFSET_W;
    localparam int BLOCK_W   = 128;
    localparam int COUNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL
    } state_t;

    // Word address of the first word of a block.
    function automatic logic [31:0] block_addr(
        input logic [TAG_W-1:0]   tag,
        input logic [INDEX_W-1:0] idx
    );
        return {tag, idx, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side request bus and data_memory-side block bus of the cache.
// slave = cache side, master = CPU/memory side.
interface dcache_if;
    import dcache_pkg::*;

    logic                 cpu_read;
    logic                 cpu_write;
    logic [31:0]          cpu_addr;
    logic [31:0]          cpu_wdata;
    logic [31:0]          cpu_rdata;
    logic                 stall;
    logic [COUNT_W-1:0]   mem_count;
    logic                 mem_write;
    logic [31:0]          mem_write_address;
    logic [BLOCK_W-1:0]   mem_write_data;
    logic [31:0]          mem_read_address;
    logic [BLOCK_W-1:0]   mem_read_data;

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_read_data,
        output cpu_rdata, stall, mem_count, mem_write,
        output mem_write_address, mem_write_data, mem_read_address
    );

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_read_data,
        input  cpu_rdata, stall, mem_count, mem_write,
        input  mem_write_address, mem_write_data, mem_read_address
    );

endinterface

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data arrays of the cache with one combinational
// read port, a word-write port and a full-line fill port.
module dcache_line_store
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INDEX_W-1:0]  rd_index,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [BLOCK_W-1:0]  rd_data,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [31:0]         wr_word,
    input  logic                fill_en,
    input  logic [INDEX_W-1:0]  fill_index,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [BLOCK_W-1:0]  fill_data
);

    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tags  [NUM_LINES];
    logic [BLOCK_W-1:0]   lines [NUM_LINES];

    assign rd_valid = valid[rd_index];
    assign rd_dirty = dirty[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = lines[rd_index];

    // Status bits: reset invalidates everything and discards dirty data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (fill_en) begin
                valid[fill_index] <= 1'b1;
                dirty[fill_index] <= 1'b0;
            end
            if (wr_en) begin
                dirty[wr_index] <= 1'b1;
            end
        end
    end

    // Tag and data storage; contents are meaningless until valid is set.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[fill_index]  <= fill_tag;
            lines[fill_index] <= fill_data;
        end
        if (wr_en) begin
            lines[wr_index][{wr_offset, 5'd0} +: 32] <= wr_word;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache controller.
// Misses write back a dirty victim, then refill a 4-word block.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int MISS_LATENCY = 20
) (
    input  logic   clk,
    input  logic   rst_n,
    dcache_if.slave bus
);

    localparam logic [COUNT_W-1:0] LAT    = COUNT_W'(MISS_LATENCY);
    localparam logic [COUNT_W-1:0] LAT_M1 = COUNT_W'(MISS_LATENCY - 1);
    localparam logic [COUNT_W-1:0] ONE    = COUNT_W'(1);

    state_t               state;
    logic [COUNT_W-1:0]   count;
    logic                 mem_write_q;
    logic [31:0]          wb_addr_q;
    logic [BLOCK_W-1:0]   wb_data_q;
    logic [TAG_W-1:0]     fill_tag_q;
    logic [INDEX_W-1:0]   fill_index_q;

    logic [OFFSET_W-1:0]  offset;
    logic [INDEX_W-1:0]   index;
    logic [TAG_W-1:0]     tag;
    logic                 req;
    logic                 idle;
    logic                 hit;
    logic                 rd_valid;
    logic                 rd_dirty;
    logic [TAG_W-1:0]     rd_tag;
    logic [BLOCK_W-1:0]   rd_data;
    logic                 wr_en;
    logic                 fill_en;

    assign offset  = bus.cpu_addr[OFFSET_W-1:0];
    assign index   = bus.cpu_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign tag     = bus.cpu_addr[31:INDEX_W+OFFSET_W];
    assign req     = bus.cpu_read | bus.cpu_write;
    assign idle    = (state == IDLE);
    assign hit     = rd_valid && (rd_tag == tag);
    assign wr_en   = bus.cpu_write && idle && hit;
    assign fill_en = (state == REFILL) && (count == ONE);

    dcache_line_store u_store (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_index   (index),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_index   (index),
        .wr_offset  (offset),
        .wr_word    (bus.cpu_wdata),
        .fill_en    (fill_en),
        .fill_index (fill_index_q),
        .fill_tag   (fill_tag_q),
        .fill_data  (bus.mem_read_data)
    );

    assign bus.stall     = req && !(idle && hit);
    assign bus.cpu_rdata = (bus.cpu_read && idle && hit)
                         ? rd_data[{offset, 5'd0} +: 32] : '0;

    assign bus.mem_count         = count;
    assign bus.mem_write         = mem_write_q;
    assign bus.mem_write_address = wb_addr_q;
    assign bus.mem_write_data    = wb_data_q;
    assign bus.mem_read_address  = block_addr(fill_tag_q, fill_index_q);

    // Miss sequencer: counter runs down per block transfer, 0 commits a write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= LAT;
            mem_write_q  <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            fill_tag_q   <= '0;
            fill_index_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    count       <= LAT;
                    mem_write_q <= 1'b0;
                    if (req && !hit) begin
                        count        <= LAT_M1;
                        fill_tag_q   <= tag;
                        fill_index_q <= index;
                        if (rd_valid && rd_dirty) begin
                            state     <= WRITEBACK;
                            wb_addr_q <= block_addr(rd_tag, index);
                            wb_data_q <= rd_data;
                        end else begin
                            state <= REFILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (count == '0) begin
                        state       <= REFILL;
                        count       <= LAT_M1;
                        mem_write_q <= 1'b0;
                    end else begin
                        count       <= count - ONE;
                        mem_write_q <= (count == ONE);
                    end
                end
                REFILL: begin
                    if (count == ONE) begin
                        state <= IDLE;
                        count <= LAT;
                    end else begin
                        count <= count - ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= LAT;
                end
            endcase
        end
    end

endmodule
